// File: rtl/alu_seq_ctrl_if.sv
// Command/result bundle between a CPU-side client and the serial-ALU sequencer.
// The client side (master) issues commands and consumes results; the
// sequencer side (slave) accepts commands and produces results.
interface alu_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    // Command channel: one parallel operation per handshake.
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;

    // Result channel: parallel result plus final ALU flag.
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_y;
    logic             res_c;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_a,
        output cmd_b,
        input  cmd_ready,
        input  res_valid,
        input  res_y,
        input  res_c,
        output res_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_a,
        input  cmd_b,
        output cmd_ready,
        output res_valid,
        output res_y,
        output res_c,
        input  res_ready
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer that makes the bit-serial ALU look like a multi-cycle parallel
// unit: it accepts one command, clears the ALU, streams both operands
// LSB-first, gathers the serial result and the final flag, then offers the
// parallel result until it is consumed.
module alu_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_seq_ctrl_if.slave      bus,
    output logic               busy,
    output logic               alu_rst_n,
    output logic [2:0]         alu_opcode,
    output logic               alu_a,
    output logic               alu_b,
    input  logic               alu_y,
    input  logic               alu_c
);
    // Bit counter wide enough to hold WIDTH.
    localparam int CW = $clog2(WIDTH + 1);
    // Counter value seen at the edge that shifts in the last serial bit.
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FLAG = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q,      state_d;
    logic             alu_rst_n_q,  alu_rst_n_d;
    logic [2:0]       alu_opcode_q, alu_opcode_d;
    logic [WIDTH-1:0] a_sh_q,       a_sh_d;
    logic [WIDTH-1:0] b_sh_q,       b_sh_d;
    logic [WIDTH-1:0] res_y_q,      res_y_d;
    logic             res_c_q,      res_c_d;
    logic [CW-1:0]    cnt_q,        cnt_d;

    // State register: everything returns to a cleared, idle ALU on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            alu_rst_n_q  <= 1'b0;
            alu_opcode_q <= 3'd0;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            res_y_q      <= '0;
            res_c_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            alu_rst_n_q  <= alu_rst_n_d;
            alu_opcode_q <= alu_opcode_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            res_y_q      <= res_y_d;
            res_c_q      <= res_c_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state logic: accept, stream WIDTH bits, capture flag, present result.
    always_comb begin
        state_d      = state_q;
        alu_rst_n_d  = alu_rst_n_q;
        alu_opcode_d = alu_opcode_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        res_y_d      = res_y_q;
        res_c_d      = res_c_q;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                // The opcode register only changes here, so the ALU sees a
                // constant opcode for the whole operation.
                if (bus.cmd_valid) begin
                    alu_opcode_d = bus.cmd_op;
                    a_sh_d       = bus.cmd_a;
                    b_sh_d       = bus.cmd_b;
                    cnt_d        = '0;
                    alu_rst_n_d  = 1'b1;
                    state_d      = RUN;
                end
            end
            RUN: begin
                // Result bits arrive LSB first, so they enter from the top and
                // settle into place after WIDTH shifts.
                res_y_d = {alu_y, res_y_q[WIDTH-1:1]};
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = FLAG;
                end
            end
            FLAG: begin
                // The flag reflects all WIDTH bits only after the last RUN
                // edge; sample it here and put the ALU back into reset.
                res_c_d     = alu_c;
                alu_rst_n_d = 1'b0;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                alu_rst_n_d = 1'b0;
            end
        endcase
    end

    // Handshake and status outputs decode directly from the state.
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_y     = res_y_q;
    assign bus.res_c     = res_c_q;
    assign busy          = (state_q != IDLE);

    // ALU drive: operands only toggle during RUN, idle low otherwise.
    assign alu_rst_n  = alu_rst_n_q;
    assign alu_opcode = alu_opcode_q;
    assign alu_a      = (state_q == RUN) & a_sh_q[0];
    assign alu_b      = (state_q == RUN) & b_sh_q[0];
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: a behavioural bit-serial ALU answers the DUT, and
// every consumed result is compared with a parallel arithmetic reference.
module tb_alu_seq_ctrl;
    localparam int W = 8;

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic       alu_rst_n;
    logic [2:0] alu_opcode;
    logic       alu_a;
    logic       alu_b;
    logic       alu_y;
    logic       alu_c;

    alu_seq_ctrl_if #(.WIDTH(W)) bus ();

    alu_seq_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .busy       (busy),
        .alu_rst_n  (alu_rst_n),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_y      (alu_y),
        .alu_c      (alu_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural serial ALU ----------------
    // One state bit per opcode (carry, running reduction, compare, or the
    // previously shifted-in bit). 'first' makes the initial value follow the
    // opcode that is current when the ALU leaves reset.
    logic stub_first, stub_st, stub_init, stub_eff, stub_next;

    always_comb begin
        stub_init = 1'b0;
        case (alu_opcode)
            3'd1, 3'd2, 3'd5: stub_init = 1'b1;
            default:          stub_init = 1'b0;
        endcase
        stub_eff = stub_first ? stub_init : stub_st;
        alu_y     = 1'b0;
        stub_next = stub_eff;
        case (alu_opcode)
            3'd0: begin
                alu_y     = alu_a ^ alu_b ^ stub_eff;
                stub_next = (alu_a & alu_b) | (alu_a & stub_eff) | (alu_b & stub_eff);
            end
            3'd1: begin
                alu_y     = alu_a ^ ~alu_b ^ stub_eff;
                stub_next = (alu_a & ~alu_b) | (alu_a & stub_eff) | (~alu_b & stub_eff);
            end
            3'd2: begin alu_y = alu_a | alu_b;    stub_next = stub_eff & alu_y; end
            3'd3: begin alu_y = alu_a & alu_b;    stub_next = stub_eff | alu_y; end
            3'd4: begin alu_y = alu_a ^ alu_b;    stub_next = stub_eff | alu_y; end
            3'd5: begin alu_y = ~(alu_a ^ alu_b); stub_next = stub_eff & alu_y; end
            3'd6: begin
                alu_y     = alu_a;
                stub_next = (alu_a & ~alu_b) ? 1'b1 : ((~alu_a & alu_b) ? 1'b0 : stub_eff);
            end
            default: begin alu_y = stub_eff; stub_next = alu_a; end
        endcase
        alu_c = stub_eff;
    end

    always @(posedge clk) begin
        if (!alu_rst_n) begin
            stub_first <= 1'b1;
            stub_st    <= 1'b0;
        end else begin
            stub_first <= 1'b0;
            stub_st    <= stub_next;
        end
    end

    // ---------------- reference model and checking ----------------
    int n_compared;
    int n_mismatched;
    int expect_acc_cyc;

    int          acc_q[$];
    logic [18:0] pend_q[$];
    logic [8:0]  res_q[$];

    // Parallel reference: {flag, result} from plain arithmetic.
    function automatic logic [8:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] y;
        logic       c;
        s = 9'd0;
        y = 8'd0;
        c = 1'b0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; y = s[7:0]; c = s[8]; end
            3'd1: begin y = a - b; c = 1'b0; end
            3'd2: begin y = a | b;    c = (y == 8'hFF); end
            3'd3: begin y = a & b;    c = (y != 8'h00); end
            3'd4: begin y = a ^ b;    c = (y != 8'h00); end
            3'd5: begin y = ~(a ^ b); c = (y == 8'hFF); end
            3'd6: begin y = a;        c = (a > b); end
            default: begin y = {a[6:0], 1'b0}; c = 1'b0; end
        endcase
        return {c, y};
    endfunction

    function automatic bit flag_defined(input logic [2:0] op);
        return (op != 3'd1) && (op != 3'd7);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: note which handshakes the coming edge completes,
    // score any result against the reference, then wait for the next negedge.
    task automatic tick();
        logic [18:0] p;
        logic [8:0]  e;
        if (bus.cmd_valid && bus.cmd_ready) begin
            acc_q.push_back(cyc);
            pend_q.push_back({bus.cmd_op, bus.cmd_a, bus.cmd_b});
        end
        if (bus.res_valid && bus.res_ready) begin
            res_q.push_back({bus.res_c, bus.res_y});
            if (pend_q.size() == 0) begin
                check_eq("sb_orphan_result", 32'd1, 32'd0);
            end else begin
                p = pend_q.pop_front();
                e = ref_alu(p[18:16], p[15:8], p[7:0]);
                $display("res op=%0d a=0x%02h b=0x%02h y=0x%02h c=%0d (ref y=0x%02h c=%0d)",
                         p[18:16], p[15:8], p[7:0], bus.res_y, bus.res_c, e[7:0], e[8]);
                check_eq("sb_res_y", 32'(bus.res_y), 32'(e[7:0]));
                if (flag_defined(p[18:16])) check_eq("sb_res_c", 32'(bus.res_c), 32'(e[8]));
            end
        end
        @(negedge clk);
    endtask

    // One operation: accept, watch the serial phase, optionally stall the
    // result (presenting a follow-up command meanwhile), then consume it.
    // dchk: 0 no directed value, 1 check y, 2 check y and flag.
    task automatic run_single(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                              input int hold, input bit nxt_en,
                              input logic [2:0] op2, input logic [7:0] a2, input logic [7:0] b2,
                              input int dchk, input logic [7:0] dy, input logic dc);
        int         n;
        int         lat;
        int         hi;
        bit         ctrl_ok;
        bit         ser_ok;
        bit         hold_ok;
        int         ab;
        int         rb;
        int         hs_cyc;
        logic [7:0] y0;
        logic       c0;
        logic [8:0] r;

        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.res_ready = 1'b0;
        ab = acc_q.size();
        n  = 0;
        while (acc_q.size() == ab && n < 50) begin tick(); n++; end
        check_eq("cmd_accepted", 32'(acc_q.size() - ab), 32'd1);
        if (acc_q.size() == ab) begin
            bus.cmd_valid = 1'b0;
            return;
        end
        if (expect_acc_cyc >= 0) begin
            check_eq("accept_after_res_hs", 32'(acc_q[$]), 32'(expect_acc_cyc));
            expect_acc_cyc = -1;
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'($urandom);
        bus.cmd_a     = 8'($urandom);
        bus.cmd_b     = 8'($urandom);

        lat     = 0;
        hi      = 0;
        ctrl_ok = 1'b1;
        ser_ok  = 1'b1;
        while (!bus.res_valid && lat < 40) begin
            if (alu_rst_n) hi++;
            if (alu_opcode != op || bus.cmd_ready || !busy) ctrl_ok = 1'b0;
            if (lat < W) begin
                if (alu_a !== a[lat] || alu_b !== b[lat]) ser_ok = 1'b0;
            end else if (alu_a !== 1'b0 || alu_b !== 1'b0) begin
                ser_ok = 1'b0;
            end
            tick();
            lat++;
        end
        check_eq("latency_edges", 32'(lat), 32'(W + 1));
        check_eq("alu_rst_n_high_cycles", 32'(hi), 32'(W + 1));
        check_eq("run_ctrl_stable", 32'(ctrl_ok), 32'd1);
        check_eq("serial_operands", 32'(ser_ok), 32'd1);

        y0 = bus.res_y;
        c0 = bus.res_c;
        if (nxt_en) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = op2;
            bus.cmd_a     = a2;
            bus.cmd_b     = b2;
        end
        hold_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            if (!bus.res_valid || bus.res_y !== y0 || bus.res_c !== c0 || bus.cmd_ready ||
                !busy || alu_rst_n || alu_a || alu_b) hold_ok = 1'b0;
            tick();
        end
        if (hold > 0) check_eq("hold_stable", 32'(hold_ok), 32'd1);

        bus.res_ready = 1'b1;
        rb     = res_q.size();
        ab     = acc_q.size();
        hs_cyc = cyc;
        tick();
        bus.res_ready = 1'b0;
        check_eq("res_handshake", 32'(res_q.size() - rb), 32'd1);
        check_eq("idle_after_hs", {29'd0, bus.cmd_ready, busy, bus.res_valid}, 32'b100);
        if (nxt_en) begin
            check_eq("no_accept_on_res_hs", 32'(acc_q.size() - ab), 32'd0);
            expect_acc_cyc = hs_cyc + 1;
        end
        if (res_q.size() > rb && dchk > 0) begin
            r = res_q[$];
            check_eq("directed_res_y", 32'(r[7:0]), 32'(dy));
            if (dchk > 1) check_eq("directed_res_c", 32'(r[8]), 32'(dc));
        end
    endtask

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       c;
        logic       cc;
    } dcase_t;

    dcase_t dir[6];

    initial begin
        int n;
        int ab;
        int rb;

        n_compared     = 0;
        n_mismatched   = 0;
        expect_acc_cyc = -1;
        rst_n          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 3'd0;
        bus.cmd_a      = 8'd0;
        bus.cmd_b      = 8'd0;
        bus.res_ready  = 1'b0;

        dir[0] = '{3'd0, 8'd200, 8'd100, 8'd44,  1'b1, 1'b1};
        dir[1] = '{3'd1, 8'd5,   8'd7,   8'd254, 1'b0, 1'b0};
        dir[2] = '{3'd7, 8'h81,  8'h5C,  8'h02,  1'b0, 1'b0};
        dir[3] = '{3'd5, 8'h5A,  8'h5A,  8'hFF,  1'b1, 1'b1};
        dir[4] = '{3'd6, 8'd9,   8'd3,   8'd9,   1'b1, 1'b1};
        dir[5] = '{3'd3, 8'hFF,  8'h0F,  8'h0F,  1'b1, 1'b1};

        // Reset state.
        repeat (3) @(negedge clk);
        check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check_eq("rst_alu_rst_n", 32'(alu_rst_n), 32'd0);
        check_eq("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        check_eq("rst_res_y", 32'(bus.res_y), 32'd0);
        check_eq("rst_res_c", 32'(bus.res_c), 32'd0);
        check_eq("rst_alu_ab", {30'd0, alu_a, alu_b}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed operations with immediate consumption.
        for (int i = 0; i < 6; i++) begin
            run_single(dir[i].op, dir[i].a, dir[i].b, 0, 1'b0, 3'd0, 8'd0, 8'd0,
                       dir[i].cc ? 2 : 1, dir[i].y, dir[i].c);
        end

        // Backpressure: OR held 5 cycles while a second command waits.
        run_single(3'd2, 8'h00, 8'h30, 5, 1'b1, 3'd4, 8'hC3, 8'h0F, 2, 8'h30, 1'b0);
        run_single(3'd4, 8'hC3, 8'h0F, 0, 1'b0, 3'd0, 8'd0, 8'd0, 2, 8'hCC, 1'b1);

        // Back-to-back with the result side always ready.
        ab = acc_q.size();
        rb = res_q.size();
        bus.res_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd0;
        bus.cmd_a     = 8'h7F;
        bus.cmd_b     = 8'h01;
        n = 0;
        while (acc_q.size() == ab && n < 50) begin tick(); n++; end
        bus.cmd_op = 3'd6;
        bus.cmd_a  = 8'h10;
        bus.cmd_b  = 8'h20;
        while (acc_q.size() < ab + 2 && n < 100) begin tick(); n++; end
        bus.cmd_valid = 1'b0;
        while (res_q.size() < rb + 2 && n < 150) begin tick(); n++; end
        bus.res_ready = 1'b0;
        check_eq("b2b_accepts", 32'(acc_q.size() - ab), 32'd2);
        if (acc_q.size() >= ab + 2) check_eq("b2b_spacing", 32'(acc_q[ab + 1] - acc_q[ab]), 32'(W + 3));
        check_eq("b2b_results", 32'(res_q.size() - rb), 32'd2);

        // Reset in the middle of RUN (bit 4 on the ALU inputs).
        ab = acc_q.size();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd0;
        bus.cmd_a     = 8'hAB;
        bus.cmd_b     = 8'h37;
        n = 0;
        while (acc_q.size() == ab && n < 50) begin tick(); n++; end
        bus.cmd_valid = 1'b0;
        repeat (4) tick();
        check_eq("midrun_active", {30'd0, busy, alu_rst_n}, 32'b11);
        rst_n = 1'b0;
        #1;
        check_eq("midrun_rst_alu_rst_n", 32'(alu_rst_n), 32'd0);
        check_eq("midrun_rst_res_valid", 32'(bus.res_valid), 32'd0);
        check_eq("midrun_rst_busy", 32'(busy), 32'd0);
        pend_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        run_single(3'd0, 8'd1, 8'd1, 0, 1'b0, 3'd0, 8'd0, 8'd0, 2, 8'd2, 1'b0);

        // Randomised operations with random result stalls.
        for (int i = 0; i < 40; i++) begin
            run_single(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                       int'($urandom_range(0, 3)), 1'b0, 3'd0, 8'd0, 8'd0, 0, 8'd0, 1'b0);
        end

        check_eq("sb_drained", 32'(pend_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequencer for the bit-serial `alu`. It accepts one parallel command (opcode plus two WIDTH-bit operands) over a valid/ready handshake. It clears the ALU, streams the operands LSB-first one bit per clock, and collects the serial result and the final flag. It then returns a parallel result over a second valid/ready handshake, so CPU-side logic can treat the serial ALU as a multi-cycle parallel unit.

Parameters:
WIDTH, 8, operand/result width = number of serial bit cycles
CW, $clog2(WIDTH+1), bit counter width (derived, not overridden)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at rising edge
cmd_op  input  3  ALU opcode (0 add, 1 sub, 2 or, 3 and, 4 xor, 5 xnor, 6 pass/cmp, 7 shl)
cmd_a  input  WIDTH  operand A
cmd_b  input  WIDTH  operand B
res_valid  output  1  result available
res_ready  input  1  result consumed when res_valid & res_ready at rising edge
res_y  output  WIDTH  parallel result
res_c  output  1  final ALU flag (carry / reduction / compare)
busy  output  1  high in any state other than IDLE
alu_rst_n  output  1  drives alu.rst_n; registered
alu_opcode  output  3  drives alu.opcode
alu_a  output  1  serial A bit to alu.a
alu_b  output  1  serial B bit to alu.b
alu_y  input  1  serial result bit from alu.y
alu_c  input  1  flag from alu.c

Behaviour:
- States: IDLE, RUN, FLAG, DONE.
- Reset values (async, on rst_n low):
  - state=IDLE, alu_rst_n=0, alu_opcode=0.
  - A/B shift regs=0, res_y=0, res_c=0, bit counter=0.
  - res_valid=0, busy=0.
- Decoded outputs:
  - cmd_ready = (state==IDLE).
  - res_valid = (state==DONE).
  - busy = (state!=IDLE).
- alu_rst_n is 1 only in RUN and FLAG, so the ALU is held cleared in IDLE/DONE. Every operation starts from a cleared ALU.
- alu_a/alu_b = LSB of the A/B shift registers in RUN, 0 in all other states.
- IDLE:
  - On cmd handshake: latch cmd_op into alu_opcode, cmd_a/cmd_b into shift regs; counter=0; alu_rst_n<=1; go RUN.
  - cmd_op/cmd_a/cmd_b are don't-care without cmd_valid.
- RUN, one bit per cycle:
  - At each edge: res_y <= {alu_y, res_y[WIDTH-1:1]}; A/B shift right by 1 (zero fill); counter+1.
  - When counter==WIDTH-1 at the edge, go FLAG.
  - RUN lasts exactly WIDTH cycles.
- FLAG, one cycle: ALU inputs driven 0, alu_rst_n still 1. At the edge: res_c <= alu_c; alu_rst_n<=0; go DONE.
- DONE:
  - res_y/res_c held stable while res_valid=1 and res_ready=0. There is no timeout.
  - On res handshake, go IDLE.
- Latency: command accepted at edge E0 → res_valid high in the cycle after edge E(WIDTH+1), i.e. 9 edges for WIDTH=8.
- Throughput: WIDTH+3 cycles per op with res_ready tied high. This is 11 for WIDTH=8: 1 IDLE, 8 RUN, 1 FLAG, 1 DONE.
- Commands are not accepted in RUN/FLAG/DONE; cmd_ready=0 applies backpressure. There is no command queue.
- alu_opcode is stable from the edge after acceptance through FLAG; it changes only on acceptance.
- Arithmetic is done entirely by the ALU; the controller does no interpretation.
  - res_y is exactly the WIDTH serial bits, bit 0 first.
  - res_c semantics depend on opcode. For sub and shl the flag carries no required meaning.
- Reset mid-operation: asynchronous return to IDLE.
  - alu_rst_n drops immediately; res_valid=0; partial result discarded.
  - cmd_ready=1 from the first cycle after rst_n rises.
- Simultaneous res handshake in DONE and cmd_valid: the command is not accepted that cycle. It is accepted in the following IDLE cycle.

Test Plan:
- ADD: cmd_op=0, a=200, b=100 → res_y=44, res_c=1; res_valid rises 9 edges after acceptance; alu_rst_n high for exactly 9 cycles.
- SUB and SHL: op=1, a=5, b=7 → res_y=254; op=7, a=0x81 → res_y=0x02.
- Logic/compare:
  - op=5, a=b=0x5A → res_y=0xFF, res_c=1.
  - op=6, a=9, b=3 → res_y=9, res_c=1.
  - op=3, a=0xFF, b=0x0F → res_y=0x0F, res_c=1.
- Backpressure: op=2, a=0, b=0x30 with res_ready=0 for 5 cycles:
  - res_y=0x30 and res_c=0 are held.
  - cmd_ready=0 and busy=1 throughout.
  - A second cmd_valid is not accepted until the cycle after the res handshake.
- Back-to-back: two commands with res_ready tied 1 → the second command is accepted exactly 11 cycles after the first; both results are correct.
- Reset mid-RUN: assert rst_n=0 at RUN bit 4 →
  - alu_rst_n=0 and res_valid=0 without waiting for a clock edge.
  - After release, a fresh add 1+1 yields res_y=2, res_c=0.
